seg_counter: RTL and testbench
==============================

SEG_COUNTER -- requirements
Module: seg_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of 7-segment digits, legal range 1..8.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a button change, legal range 1..2^20.
REQ-003 The block SHALL have parameter BCD, default 0: 0 counts each digit in hex (0..F), 1 counts each digit in decimal (0..9).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port button_inc, input, 1 bit: raw, asynchronous, active-low increment button.
REQ-007 The block SHALL have port button_dec, input, 1 bit: raw, asynchronous, active-low decrement button; present only with SEG_COUNTER_DOWN_EN.
REQ-008 The block SHALL have port count, output, 4*DIGITS bits: the counter value, with digit 0 in bits [3:0].
REQ-009 The block SHALL have port digit, output, 7*DIGITS bits: active-low segments {g,f,e,d,c,b,a} per digit, with digit 0 in bits [6:0].
REQ-010 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when count wraps in either direction.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser, then be inverted so that pressed = 1.
REQ-012 A per-button debouncer SHALL flip its debounced state only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any interruption SHALL clear its stability counter to 0.
REQ-013 A 0->1 transition of the debounced state SHALL produce exactly one single-cycle press pulse; releases and holds SHALL produce none.
REQ-014 With button_inc held low steadily, count SHALL change on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples it low.
REQ-015 An inc pulse SHALL add 1 to count, with per-digit carry at F (BCD=0) or 9 (BCD=1).
REQ-016 A dec pulse SHALL subtract 1 from count, with per-digit borrow to F or 9 respectively.
REQ-017 Incrementing from the all-max value SHALL give 0, and decrementing from 0 SHALL give all-max; in the same edge, wrap SHALL be 1 for exactly one cycle.
REQ-018 Simultaneous inc and dec pulses SHALL leave count unchanged and keep wrap at 0.
REQ-019 digit SHALL be a combinational decode of count.
REQ-020 The decode table SHALL be, in hex, 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
REQ-021 When BCD=1, nibble codes A..F SHALL never occur in count.

Reset
REQ-022 While reset is 1 at a rising edge, the block SHALL clear count to 0, clear wrap to 0, clear the synchronisers to released, set the debounced states to released, clear the stability counters to 0, and clear the press pulses.
REQ-023 digit SHALL therefore show 40 (hex) on every digit during and after reset.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.
REQ-025 A button held through reset deassertion SHALL yield exactly one press, DEBOUNCE_CYCLES+3 edges after the first non-reset edge.

Configuration
REQ-026 With macro SEG_COUNTER_DOWN_EN defined, the block SHALL include port button_dec, its synchroniser, its debouncer and the decrement path.
REQ-027 Without SEG_COUNTER_DOWN_EN, the block SHALL omit port button_dec and its logic, leaving count as up-only; REQ-016 and REQ-018 then do not apply.

Structure
REQ-028 Package seg_pkg SHALL hold the 16-entry segment constant table, the blank code 7F (hex), and the BCD/hex digit-max constants.
REQ-029 The block SHALL use one sub-module, btn_debounce (synchroniser, debouncer and press pulse), instantiated once per button.
REQ-030 The 7-segment decode SHALL be a package function, not a module.

Verification
REQ-031 With DIGITS=2, BCD=0, DEBOUNCE_CYCLES=4, the bench SHALL hold button_inc low for 20 cycles, then release it; count SHALL go 00->01 on edge 7, with exactly one increment.
REQ-032 The bench SHALL pulse button_inc low for 3 cycles, below the debounce threshold; count SHALL be unchanged and wrap SHALL stay 0.
REQ-033 With DIGITS=2, BCD=1, count=99, the bench SHALL apply one press; count SHALL become 00, wrap SHALL be 1 for one cycle, and digit SHALL become 4040 (hex).
REQ-034 With SEG_COUNTER_DOWN_EN defined and count=00, BCD=0, the bench SHALL apply a dec press; count SHALL become FF, wrap SHALL pulse, and digit SHALL become 0E0E (hex).
REQ-035 With SEG_COUNTER_DOWN_EN defined, the bench SHALL press both buttons with identical timing; count SHALL be unchanged.
REQ-036 The bench SHALL assert reset for 1 cycle while button_inc has been low for 2 cycles and is still held; count SHALL be 0, and exactly one increment SHALL follow DEBOUNCE_CYCLES+3 edges after reset deasserts.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment constants, digit limits and segment decode helper.
package seg_pkg;

    // Active-low segments {g,f,e,d,c,b,a} indexed by nibble value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] HEX_MAX = 4'hF;
    localparam logic [3:0] BCD_MAX = 4'h9;

    // Nibble to active-low segment pattern
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg_counter_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability debouncer, press pulse.
// The press pulse is issued on the same edge the debounced state flips, so a
// steady press reaches the counter DEBOUNCE_CYCLES+3 edges after first sample.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          pressed_c;
    logic          stable;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; idles at released (high)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    assign pressed_c = ~sync2;

    // Flip debounced state after LAST+1 consecutive differing cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (pressed_c != stable) begin
                if (cnt == LAST) begin
                    stable <= pressed_c;
                    cnt    <= '0;
                    press  <= pressed_c;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/seg_counter.sv
// Debounced button up/down counter with per-digit 7-segment decode.
// Optional decrement button and path enabled by macro SEG_COUNTER_DOWN_EN.
module seg_counter
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BCD             = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_inc,
`ifdef SEG_COUNTER_DOWN_EN
    input  logic                  button_dec,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   digit,
    output logic                  wrap
);

    localparam logic [3:0] DMAX = (BCD != 0) ? BCD_MAX : HEX_MAX;

    logic                inc_press;
    logic                step_up_c;
    logic                carry_c;
    logic                wrap_c;
    logic [4*DIGITS-1:0] next_count_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk    (clk),
        .reset  (reset),
        .button (button_inc),
        .press  (inc_press)
    );

`ifdef SEG_COUNTER_DOWN_EN
    logic dec_press;
    logic step_dn_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk    (clk),
        .reset  (reset),
        .button (button_dec),
        .press  (dec_press)
    );

    // Opposing presses in the same cycle cancel
    assign step_up_c = inc_press & ~dec_press;
    assign step_dn_c = dec_press & ~inc_press;
`else
    assign step_up_c = inc_press;
`endif

    // Ripple carry/borrow across digits; final carry out is the wrap
    always_comb begin
        next_count_c = count;
        carry_c      = 1'b0;
        wrap_c       = 1'b0;
        if (step_up_c) begin
            carry_c = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (carry_c) begin
                    if (count[4*i +: 4] == DMAX) begin
                        next_count_c[4*i +: 4] = 4'h0;
                    end else begin
                        next_count_c[4*i +: 4] = count[4*i +: 4] + 4'h1;
                        carry_c = 1'b0;
                    end
                end
            end
            wrap_c = carry_c;
        end
`ifdef SEG_COUNTER_DOWN_EN
        else if (step_dn_c) begin
            carry_c = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (carry_c) begin
                    if (count[4*i +: 4] == 4'h0) begin
                        next_count_c[4*i +: 4] = DMAX;
                    end else begin
                        next_count_c[4*i +: 4] = count[4*i +: 4] - 4'h1;
                        carry_c = 1'b0;
                    end
                end
            end
            wrap_c = carry_c;
        end
`endif
    end

    // Counter and wrap pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count_c;
            wrap  <= wrap_c;
        end
    end

    // Segment decode of each digit
    always_comb begin
        digit = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit[7*i +: 7] = seg_decode(count[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_seg_counter.sv
// Directed bench: hex and BCD instances share clock, reset and buttons.
module tb_seg_counter;

    localparam int unsigned DIG = 2;
    localparam int unsigned DEB = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        button_inc = 1'b1;
    logic        button_dec = 1'b1;
    logic [7:0]  count_h, count_b;
    logic [13:0] digit_h, digit_b;
    logic        wrap_h, wrap_b;

    int total   = 0;
    int bad     = 0;
    int wraps_h = 0;
    int wraps_b = 0;
    int snap_h;
    int snap_b;

    always #5 clk = ~clk;

    seg_counter #(.DIGITS(DIG), .DEBOUNCE_CYCLES(DEB), .BCD(0)) dut_h (
        .clk        (clk),
        .reset      (reset),
        .button_inc (button_inc),
`ifdef SEG_COUNTER_DOWN_EN
        .button_dec (button_dec),
`endif
        .count      (count_h),
        .digit      (digit_h),
        .wrap       (wrap_h)
    );

    seg_counter #(.DIGITS(DIG), .DEBOUNCE_CYCLES(DEB), .BCD(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .button_inc (button_inc),
`ifdef SEG_COUNTER_DOWN_EN
        .button_dec (button_dec),
`endif
        .count      (count_b),
        .digit      (digit_b),
        .wrap       (wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges, sampling at the following falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            wraps_h += int'(wrap_h);
            wraps_b += int'(wrap_b);
        end
    endtask

    task automatic press(input bit do_inc, input bit do_dec);
        button_inc = ~do_inc;
        button_dec = ~do_dec;
        tick(8);
        button_inc = 1'b1;
        button_dec = 1'b1;
        tick(8);
    endtask

    // Press with edge-exact checks around the update edge DEB+3
    task automatic press_watch(input string tag, input bit do_inc, input bit do_dec,
                               input logic [7:0] old_h, input logic [7:0] old_b,
                               input logic [7:0] new_h, input logic [7:0] new_b,
                               input logic wr_h, input logic wr_b);
        button_inc = ~do_inc;
        button_dec = ~do_dec;
        tick(DEB + 2);
        check({tag, "_pre_h"}, 32'(count_h), 32'(old_h));
        check({tag, "_pre_b"}, 32'(count_b), 32'(old_b));
        tick(1);
        check({tag, "_cnt_h"}, 32'(count_h), 32'(new_h));
        check({tag, "_cnt_b"}, 32'(count_b), 32'(new_b));
        check({tag, "_wrap_h"}, 32'(wrap_h), 32'(wr_h));
        check({tag, "_wrap_b"}, 32'(wrap_b), 32'(wr_b));
        tick(1);
        check({tag, "_wrap_off_h"}, 32'(wrap_h), 32'd0);
        check({tag, "_wrap_off_b"}, 32'(wrap_b), 32'd0);
        tick(4);
        button_inc = 1'b1;
        button_dec = 1'b1;
        tick(8);
    endtask

    initial begin
        @(negedge clk);
        // Reset state, during and after reset
        tick(2);
        check("rst_cnt_h", 32'(count_h), 32'h0);
        check("rst_wrap_h", 32'(wrap_h), 32'h0);
        check("rst_digit_h", 32'(digit_h), 32'({7'h40, 7'h40}));
        check("rst_digit_b", 32'(digit_b), 32'({7'h40, 7'h40}));
        reset = 1'b0;
        tick(3);
        check("post_rst_cnt_b", 32'(count_b), 32'h0);

        // Long hold: single increment on edge DEB+3 = 7
        snap_h = wraps_h;
        button_inc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check($sformatf("hold_e%0d", k), 32'(count_h), (k >= 7) ? 32'h1 : 32'h0);
        end
        button_inc = 1'b1;
        tick(12);
        check("hold_once", 32'(count_h), 32'h1);
        check("hold_digit", 32'(digit_h), 32'({7'h40, 7'h79}));
        check("hold_nowrap", 32'(wraps_h - snap_h), 32'd0);

        // Short glitch below threshold
        snap_h = wraps_h;
        button_inc = 1'b0;
        tick(3);
        button_inc = 1'b1;
        tick(15);
        check("glitch_cnt", 32'(count_h), 32'h1);
        check("glitch_nowrap", 32'(wraps_h - snap_h), 32'd0);

        // Bring counters to 99 presses
        for (int i = 0; i < 98; i++) press(1'b1, 1'b0);
        check("p99_b", 32'(count_b), 32'h99);
        check("p99_h", 32'(count_h), 32'h63);
        check("p99_digit_b", 32'(digit_b), 32'({7'h10, 7'h10}));

        // BCD wrap 99 -> 00
        snap_b = wraps_b;
        press_watch("bcdwrap", 1'b1, 1'b0, 8'h63, 8'h99, 8'h64, 8'h00, 1'b0, 1'b1);
        check("bcdwrap_digit", 32'(digit_b), 32'({7'h40, 7'h40}));
        check("bcdwrap_pulses", 32'(wraps_b - snap_b), 32'd1);

        // Hex wrap FF -> 00
        for (int i = 0; i < 155; i++) press(1'b1, 1'b0);
        check("pff_h", 32'(count_h), 32'hFF);
        check("pff_b", 32'(count_b), 32'h55);
        snap_h = wraps_h;
        press_watch("hexwrap", 1'b1, 1'b0, 8'hFF, 8'h55, 8'h00, 8'h56, 1'b1, 1'b0);
        check("hexwrap_pulses", 32'(wraps_h - snap_h), 32'd1);
        check("hexwrap_digit", 32'(digit_h), 32'({7'h40, 7'h40}));

`ifdef SEG_COUNTER_DOWN_EN
        // Decrement borrow 00 -> FF
        press_watch("decwrap", 1'b0, 1'b1, 8'h00, 8'h56, 8'hFF, 8'h55, 1'b1, 1'b0);
        check("decwrap_digit", 32'(digit_h), 32'({7'h0E, 7'h0E}));
        // Simultaneous presses cancel
        press_watch("both", 1'b1, 1'b1, 8'hFF, 8'h55, 8'hFF, 8'h55, 1'b0, 1'b0);
`endif

        // Reset mid-hold: partial debounce discarded, one press after release of reset
        button_inc = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_cnt", 32'(count_h), 32'h0);
        check("midrst_cnt_b", 32'(count_b), 32'h0);
        tick(6);
        check("midrst_e6", 32'(count_h), 32'h0);
        tick(1);
        check("midrst_e7", 32'(count_h), 32'h1);
        tick(10);
        button_inc = 1'b1;
        tick(10);
        check("midrst_once", 32'(count_h), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
